wb_slave_mem: RTL
=================

Name: wb_slave_mem

Overview:
- Wishbone B3 classic single-cycle slave that responds to the Amber core's Wishbone master port.
- Sits on the core's instruction/data bus as a word-addressed local memory with byte-lane writes.
- Provides a programmable wait-state count so the bench can exercise master stall behaviour.
- Always returns ack/err with known data, pairing with the master-side protocol assertions.

Parameters:
- ADDR_WIDTH, 8, word-address bits; memory depth is 2**ADDR_WIDTH 32-bit words.
- BASE_ADR, 32'h0000_0000, byte base address of the window; must be aligned to the window size.
- WAIT_STATES, 1, extra cycles inserted between strobe capture and response; legal range 0..15.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- i_wb_cyc  input  1  bus cycle valid from master
- i_wb_stb  input  1  strobe, transfer request
- i_wb_we  input  1  1 = write, 0 = read
- i_wb_adr  input  32  byte address
- i_wb_sel  input  4  byte lane enables; bit n selects dat[8n+7:8n]
- i_wb_dat  input  32  write data
- o_wb_dat  output  32  read data, valid only while o_wb_ack = 1
- o_wb_ack  output  1  normal termination, one-cycle pulse
- o_wb_err  output  1  error termination, one-cycle pulse

Behaviour:
- Reset (reset_n low, asynchronous):
  - o_wb_ack = 0, o_wb_err = 0, o_wb_dat = 0.
  - FSM to IDLE, wait counter to 0, all memory words to 0.
  - Reset asserted mid-transfer aborts it: no write commits and no response is issued.
- FSM states IDLE, WAIT, RESP, all outputs registered:
  - IDLE: on a clock edge with i_wb_cyc & i_wb_stb, capture adr/we/sel/dat and decode the request. Go to WAIT and load counter = WAIT_STATES-1 if WAIT_STATES > 0, else go to RESP.
  - WAIT: decrement counter each cycle; go to RESP when counter = 0.
  - RESP: exactly one of ack/err is high for exactly one cycle, then IDLE unconditionally.
- Latency: strobe sampled at edge N gives ack/err high during the cycle after edge N+1+WAIT_STATES. Minimum latency is 1 cycle.
- Back-to-back: ack/err are low for at least one cycle between transfers. A strobe held high after ack is treated as a new transfer when sampled in IDLE.
- Decode, performed on the captured address:
  - Misaligned (adr[1:0] != 0) -> err.
  - Outside [BASE_ADR, BASE_ADR + 4*2**ADDR_WIDTH) -> err.
  - Otherwise word index = adr[ADDR_WIDTH+1:2] -> ack.
- Write:
  - Commits on the edge entering RESP, only for lanes with sel = 1.
  - sel = 4'b0000 still acks but changes no data.
  - o_wb_dat = 0 during a write ack.
- Read:
  - o_wb_dat is loaded on the edge entering RESP with the word at the index.
  - Lanes with sel = 0 read as 0.
  - Read data reflects all writes completed earlier.
- Error response: no memory update, o_wb_dat = 0.
- o_wb_dat is forced to 0 in every cycle where o_wb_ack = 0.
- Cycle abort: if i_wb_cyc falls while in WAIT, return to IDLE. No write commits and no ack/err is issued. i_wb_stb falling alone while cyc stays high does not abort.
- Request changes while in WAIT/RESP are ignored, because the captured values are used.
- Width rule: counter is 4 bits. Out-of-range WAIT_STATES is a compile-time error via a generate-time check.

Decomposition:
- Shared package wb_pkg:
  - enum wb_slv_state_t {IDLE, WAIT, RESP}
  - constants WB_ADR_W = 32, WB_DAT_W = 32, WB_SEL_W = 4
- Sub-module wb_slave_mem_array: 2**ADDR_WIDTH x 32 storage.
  - Async-reset clear.
  - Per-byte write enables, synchronous write, registered read port.
  - The FSM top instantiates it once.

Test Plan:
- Reset values: reset_n low for 3 cycles with cyc = stb = 1 -> ack = err = 0 and dat = 0 throughout. Releasing reset starts a transfer from IDLE.
- Write/read, WAIT_STATES = 1:
  - Write 32'hDEAD_BEEF to adr 32'h10, sel 4'hF -> ack exactly 2 cycles after strobe capture.
  - Read of adr 32'h10 -> ack with dat = 32'hDEAD_BEEF.
- Byte lanes:
  - Write 32'h1122_3344 to 32'h20 with sel 4'hF, then 32'hAABB_CCDD with sel 4'b0101.
  - Read with sel 4'hF -> 32'h11BB_33DD. Read with sel 4'b0011 -> 32'h0000_33DD.
- Errors:
  - Read at 32'h0000_0402 (misaligned) -> err for 1 cycle, ack = 0, dat = 0.
  - Write at 32'h0000_0400 (out of range, ADDR_WIDTH = 8) -> err and no memory change.
- Back-to-back, WAIT_STATES = 0: hold stb = 1 for 4 reads -> ack pattern 1,0,1,0,1,0,1 with ack low between every pair.
- Abort, WAIT_STATES = 3: drop cyc 1 cycle after a write to 32'h30 with 32'h5555_AAAA -> no ack/err. A subsequent read of 32'h30 returns the prior value 32'h0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: bus widths, slave FSM states and a
// byte-lane mask helper.
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } wb_slv_state_t;

  // Expand a byte-lane select into a bit mask over the data word.
  function automatic logic [WB_DAT_W-1:0] sel_to_mask(input logic [WB_SEL_W-1:0] sel);
    logic [WB_DAT_W-1:0] m;
    m = '0;
    for (int b = 0; b < WB_SEL_W; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_slave_mem_array.sv
// Word-addressed storage split into byte lanes: per-lane synchronous write,
// registered read, asynchronously cleared.
module wb_slave_mem_array
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WB_SEL_W-1:0]   we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] idx_i,
  input  logic [WB_DAT_W-1:0]   wdat_i,
  output logic [WB_DAT_W-1:0]   rdat_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  for (genvar gi = 0; gi < WB_SEL_W; gi++) begin : g_lane
    logic [7:0] lane_q [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int w = 0; w < DEPTH; w++) begin
          lane_q[w] <= '0;
        end
        rd_q <= '0;
      end else begin
        if (we_i[gi]) begin
          lane_q[idx_i] <= wdat_i[8*gi +: 8];
        end
        if (re_i) begin
          rd_q <= lane_q[idx_i];
        end
      end
    end

    assign rdat_o[8*gi +: 8] = rd_q;
  end

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone B3 classic slave with local word memory, byte-lane writes,
// address/alignment error decode and a programmable wait-state count.
module wb_slave_mem
  import wb_pkg::*;
#(
  parameter int                  ADDR_WIDTH  = 8,
  parameter logic [WB_ADR_W-1:0] BASE_ADR    = 32'h0000_0000,
  parameter int                  WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  input  logic                i_wb_we,
  input  logic [WB_ADR_W-1:0] i_wb_adr,
  input  logic [WB_SEL_W-1:0] i_wb_sel,
  input  logic [WB_DAT_W-1:0] i_wb_dat,
  output logic [WB_DAT_W-1:0] o_wb_dat,
  output logic                o_wb_ack,
  output logic                o_wb_err
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_check
    $error("wb_slave_mem: WAIT_STATES must be in 0..15");
  end

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit         NO_WAIT = (WAIT_STATES == 0);

  wb_slv_state_t         state_q;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic                  ok_q;
  logic [WB_SEL_W-1:0]   sel_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [WB_DAT_W-1:0]   wdat_q;
  logic                  ack_q;
  logic                  err_q;
  logic [WB_DAT_W-1:0]   dat_q;

  logic                  req_live;
  logic                  live_ok;
  logic                  from_idle;
  logic                  from_wait;
  logic [WB_SEL_W-1:0]   mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_idx;
  logic [WB_DAT_W-1:0]   mem_wdat;
  logic [WB_DAT_W-1:0]   mem_rdat;

  assign req_live = i_wb_cyc & i_wb_stb;
  // Base is window-aligned, so the window test reduces to matching the upper bits.
  assign live_ok  = (i_wb_adr[1:0] == 2'b00) &&
                    (i_wb_adr[WB_ADR_W-1:ADDR_WIDTH+2] == BASE_ADR[WB_ADR_W-1:ADDR_WIDTH+2]);

  // Memory access happens on the edge entering RESP; with no wait states that
  // edge is the capture edge, so the live bus values are used directly.
  always_comb begin
    from_idle = NO_WAIT && (state_q == IDLE) && req_live;
    from_wait = (state_q == WAIT) && i_wb_cyc && (cnt_q == 4'd0);
    mem_we    = '0;
    mem_re    = 1'b0;
    mem_idx   = idx_q;
    mem_wdat  = wdat_q;
    if (from_idle) begin
      mem_idx  = i_wb_adr[ADDR_WIDTH+1:2];
      mem_wdat = i_wb_dat;
      if (live_ok) begin
        if (i_wb_we) mem_we = i_wb_sel;
        else         mem_re = 1'b1;
      end
    end else if (from_wait && ok_q) begin
      if (we_q) mem_we = sel_q;
      else      mem_re = 1'b1;
    end
  end

  wb_slave_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk    (clk),
    .reset_n(reset_n),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .idx_i  (mem_idx),
    .wdat_i (mem_wdat),
    .rdat_o (mem_rdat)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ok_q    <= 1'b0;
      sel_q   <= '0;
      idx_q   <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= '0;
      case (state_q)
        IDLE: begin
          if (req_live) begin
            we_q   <= i_wb_we;
            ok_q   <= live_ok;
            sel_q  <= i_wb_sel;
            idx_q  <= i_wb_adr[ADDR_WIDTH+1:2];
            wdat_q <= i_wb_dat;
            if (NO_WAIT) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WS_LOAD;
            end
          end
        end
        WAIT: begin
          if (!i_wb_cyc)            state_q <= IDLE;
          else if (cnt_q == 4'd0)   state_q <= RESP;
          else                      cnt_q   <= cnt_q - 4'd1;
        end
        RESP: begin
          ack_q   <= ok_q;
          err_q   <= ~ok_q;
          if (ok_q && !we_q) begin
            dat_q <= mem_rdat & sel_to_mask(sel_q);
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_err = err_q;
  assign o_wb_dat = dat_q;

endmodule
